// File: rtl/rr_arb_mux4_pkg.sv
// Shared constants, the channel-select type and the round-robin pointer
// helper for the 4:1 arbitrated merge stage.
package mux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // The type is 2 bits wide, so the increment wraps 3 -> 0 by itself.
    function automatic sel_t next_ptr(input sel_t p);
        return p + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter. Requests are scanned from ptr upward,
// modulo 4, and the first asserted request wins.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  sel_t           ptr,
    output logic           grant_valid,
    output sel_t           grant_idx
);

    // The scan runs from farthest to nearest, so the request closest to ptr
    // is written last and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[ptr + sel_t'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = ptr + sel_t'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux4.sv
// Registered round-robin 4:1 merge. A fair grant loads a one-entry output
// register that holds the data and its source index for the downstream mux.
module rr_arb_mux4
    import mux_pkg::sel_t;
    import mux_pkg::next_ptr;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel,
    input  logic                 out_ready
);

    sel_t             r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    sel_t             r_out_sel;

    logic             w_can_accept;
    logic             w_grant_valid;
    sel_t             w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_grant_data;

    rr_arbiter4 u_arb (
        .req         (in_valid),
        .ptr         (r_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant)
    );

    // The slot is free when it is empty or drains this cycle, so a new entry
    // can replace the old one on the same edge without a bubble.
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_xfer       = !rst && w_can_accept && w_grant_valid;
    assign w_grant_data = in_data[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (w_xfer) in_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_ptr       <= next_ptr(w_grant);
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_sel   <= w_grant;
        end else if (out_ready) begin
            // Data and sel keep their last values after the entry drains.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Randomized and directed bench for rr_arb_mux4. A queue scoreboard is fed
// from a priority-list reference model, and a separate monitor drains it.
module tb_rr_arb_mux4;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    rr_arb_mux4 #(.WIDTH(W), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    // Each queue entry is one expected output: {sel, data}.
    logic [9:0] sb_q[$];

    // Reference model state.
    int         m_ptr;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_os;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. gx returns the granted channel, or -1 when there is none.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rdy,
                        input logic r, output int gx);
        bit   ca;
        int   g;
        logic [3:0] exp_rdy;
        @(posedge clk); #1;
        in_valid = v; in_data = d; out_ready = rdy; rst = r;
        // Priority list: ptr, ptr+1, ptr+2, ptr+3; the first valid channel wins.
        ca = !m_ov || rdy;
        g  = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (r || !ca) g = -1;
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("out_data", int'(out_data), int'(m_od));
        chk("out_sel", int'(out_sel), m_os);
        #2;
        if (r) begin
            m_ov = 0; m_od = 8'h00; m_os = 0; m_ptr = 0;
            sb_q.delete();
        end else if (g >= 0) begin
            m_od  = d[g*8 +: 8];
            m_os  = g;
            m_ov  = 1;
            m_ptr = (g + 1) % 4;
            sb_q.push_back({2'(g), m_od});
        end else if (rdy) begin
            m_ov = 0;
        end
        gx = g;
    endtask

    // Monitor: whenever an entry is presented, it must match the oldest
    // expected entry. The entry is retired when downstream takes it.
    initial begin
        logic [9:0] e;
        while (!done) begin
            @(negedge clk);
            if (!done && out_valid) begin
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_empty: out_sel %0d out_data %0h with nothing expected", out_sel, out_data);
                end else begin
                    e = sb_q[0];
                    chk("sb_sel", int'(out_sel), int'(e[9:8]));
                    chk("sb_data", int'(out_data), int'(e[7:0]));
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int         gx;
        logic [3:0] vld;
        logic [31:0] dat;
        logic       rdy;
        logic       r;
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        m_ptr = 0; m_ov = 0; m_od = 8'h00; m_os = 0;

        // Reset held for 3 cycles with every channel valid.
        repeat (3) step(4'hF, 32'h13121110, 1'b1, 1'b1, gx);
        // Single channel: only ch2 is valid, with A5.
        step(4'b0100, 32'h00A50000, 1'b1, 1'b0, gx);
        chk("single_grant", gx, 2);
        step(4'b0000, 32'h0, 1'b1, 1'b0, gx);
        // Round robin from a fresh pointer: grants 0,1,2,3,0.
        step(4'hF, 32'h13121110, 1'b1, 1'b1, gx);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 32'h13121110, 1'b1, 1'b0, gx);
            chk("rr_grant", gx, i % 4);
        end
        // Back-pressure: hold the ch1 entry while ch0 and ch3 wait.
        step(4'b0010, 32'h00003C00, 1'b1, 1'b0, gx);
        repeat (5) step(4'b1001, 32'h13000010, 1'b0, 1'b0, gx);
        step(4'b1001, 32'h13000010, 1'b1, 1'b0, gx);
        chk("bp_grant", gx, 3);
        step(4'b0001, 32'h00000010, 1'b1, 1'b0, gx);
        // Wrap-around: a ch2 grant moves ptr to 3, then ch0 wins and ptr wraps.
        step(4'b0100, 32'h00770000, 1'b1, 1'b0, gx);
        step(4'b0001, 32'h00000055, 1'b1, 1'b0, gx);
        chk("wrap_grant", gx, 0);
        repeat (2) step(4'b0000, 32'h0, 1'b1, 1'b0, gx);
        // Reset asserted mid-stream.
        repeat (2) step(4'hF, 32'h13121110, 1'b1, 1'b0, gx);
        step(4'hF, 32'h13121110, 1'b1, 1'b1, gx);
        step(4'hF, 32'h13121110, 1'b1, 1'b0, gx);
        chk("post_rst_grant", gx, 0);
        repeat (2) step(4'hF, 32'h13121110, 1'b1, 1'b0, gx);

        // Random traffic. A channel keeps its valid and data until it is granted.
        vld = '0; dat = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++)
                if (!vld[c] && ($urandom % 2 == 0)) begin
                    vld[c] = 1'b1;
                    dat[c*8 +: 8] = 8'($urandom);
                end
            rdy = ($urandom % 4 != 0);
            r   = ($urandom % 97 == 0);
            step(vld, dat, rdy, r, gx);
            if (gx >= 0) vld[gx] = 1'b0;
        end
        step(4'b0000, 32'h0, 1'b1, 1'b0, gx);
        step(4'b0000, 32'h0, 1'b1, 1'b0, gx);
        chk("sb_drained", sb_q.size(), 0);

        done = 1'b1;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
